// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives an 8N1 framed image (A5, LEN_H, LEN_L, data, CSUM) and writes it into program memory.
// Optional PROG_LOADER_TIMEOUT_EN aborts a load after TIMEOUT_CYC idle cycles between bytes.
module uart_prog_loader #(
    parameter int CLK_HZ      = 27000000,
    parameter int BAUD        = 115200,
    parameter int DEPTH       = 2048,
    parameter int TIMEOUT_CYC = 2700000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA, CSUM, OK, ERR} state_t;

    rx_state_t   rx_state_q, rx_state_d;
    state_t      state_q, state_d;
    logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;
    logic [3:0]  len_h_q, len_h_d;
    logic [11:0] cnt_q, cnt_d, addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [7:0]  sum_q, sum_d, mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [11:0] len;
    logic        too_long, active, timeout;

    always_comb begin
        sync1_d      = rx;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == CW'(HALF - 1)) begin
                rx_cnt_d   = '0;
                bit_d      = '0;
                rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == CW'(DIV - 1)) begin
                rx_cnt_d   = '0;
                shift_d    = {sync2_q, shift_q[7:1]};
                bit_d      = bit_q + 3'd1;
                rx_state_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
            default: if (rx_cnt_q == CW'(DIV - 1)) begin
                rx_state_d   = RX_IDLE;
                byte_valid_d = sync2_q;
                frame_err_d  = !sync2_q;
            end
        endcase
    end

    assign len      = {len_h_q, shift_q};
    assign too_long = {1'b0, len} > 13'(DEPTH);
    assign active   = state_q inside {LEN_H, LEN_L, DATA, CSUM};

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    logic [GW-1:0] gap_q, gap_d;
    always_comb gap_d = (byte_valid_q || !active) ? '0 : gap_q + 1'b1;
    assign timeout = active && !byte_valid_q && gap_q == GW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk) gap_q <= reset ? '0 : gap_d;
`else
    assign timeout = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        state_d     = state_q;
        len_h_d     = len_h_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        case (state_q)
            IDLE: if (byte_valid_q && shift_q == 8'hA5) begin
                state_d = LEN_H;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            LEN_H: if (byte_valid_q) begin
                len_h_d = shift_q[3:0];
                state_d = LEN_L;
            end
            LEN_L: if (byte_valid_q) begin
                cnt_d   = len;
                addr_d  = '0;
                sum_d   = '0;
                state_d = too_long ? ERR : (len == '0 ? CSUM : DATA);
            end
            DATA: if (byte_valid_q) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = shift_q;
                addr_d      = addr_q + 12'd1;
                sum_d       = sum_q + shift_q;
                cnt_d       = cnt_q - 12'd1;
                state_d     = (cnt_q == 12'd1) ? CSUM : DATA;
            end
            CSUM: if (byte_valid_q) state_d = (shift_q == sum_q) ? OK : ERR;
            OK: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            ERR: begin
                err_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A broken frame or a stalled sender invalidates the load in progress.
        if (active && (frame_err_q || timeout)) state_d = ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            prev_q       <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= IDLE;
            len_h_q      <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            len_h_q      <= len_h_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            sum_q        <= sum_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: drives UART frames into uart_prog_loader and checks writes/status against a frame-parsing model.
module tb_uart_prog_loader;
    localparam int DIV = 10;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        mem_we, busy, done, err;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;

    int errors = 0;
    int checks = 0;
    int long_pulses = 0;
    logic we_prev = 1'b0;
    logic [19:0] obs_w[$];
    logic [19:0] exp_w[$];
    logic exp_done = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_HZ(1000000), .BAUD(100000), .DEPTH(2048), .TIMEOUT_CYC(500)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (mem_we) obs_w.push_back({mem_addr, mem_wdata});
        if (mem_we && we_prev) long_pulses++;
        we_prev = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Parses a byte stream the way a frame is defined, appending expected writes and updating sticky flags.
    task automatic model(input bq_t s);
        int i = 0;
        int len;
        logic [7:0] sum;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_busy = 1'b1;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (i + 2 >= s.size()) return;
            len = int'(s[i+1][3:0]) * 256 + int'(s[i+2]);
            i += 3;
            if (len > 2048) begin
                exp_busy = 1'b0;
                exp_err  = 1'b1;
                continue;
            end
            sum = 8'h00;
            for (int k = 0; k < len; k++) begin
                if (i >= s.size()) return;
                exp_w.push_back({12'(k), s[i]});
                sum += s[i];
                i++;
            end
            if (i >= s.size()) return;
            exp_busy = 1'b0;
            if (s[i] == sum) exp_done = 1'b1;
            else exp_err = 1'b1;
            i++;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, ".nwr"}, obs_w.size(), exp_w.size());
        for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++)
            check($sformatf("%s.wr%0d", tag, k), 32'(obs_w[k]), 32'(exp_w[k]));
        check({tag, ".done"}, 32'(done), 32'(exp_done));
        check({tag, ".err"}, 32'(err), 32'(exp_err));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        check({tag, ".pulse"}, long_pulses, 0);
    endtask

    task automatic run(input bq_t s, input string tag);
        obs_w.delete();
        exp_w.delete();
        model(s);
        foreach (s[j]) send_byte(s[j]);
        repeat (20) @(negedge clk);
        check_result(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".we"}, 32'(mem_we), 0);
        check({tag, ".addr"}, 32'(mem_addr), 0);
        check({tag, ".wdata"}, 32'(mem_wdata), 0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        check({tag, ".err"}, 32'(err), 0);
    endtask

    initial begin
        bq_t q;
        logic [7:0] cs;
        int n;
        repeat (5) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        q = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run(q, "good3");
        q = '{8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h31};
        run(q, "badsum");
        q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run(q, "len0");
        q = '{8'hA5, 8'h08, 8'h01};
        run(q, "toolong");
        q = '{8'hA5, 8'hF0, 8'h01, 8'hA5, 8'hA5};
        run(q, "hinib");

        obs_w.delete();
        exp_w.delete();
        q = '{8'hA5, 8'h00, 8'h03, 8'h11};
        model(q);
        foreach (q[j]) send_byte(q[j]);
        send_byte(8'h22, 1'b0);
        repeat (20) @(negedge clk);
        exp_busy = 1'b0;
        exp_err  = 1'b1;
        check_result("framing");

        obs_w.delete();
        q = '{8'hA5, 8'h00, 8'h05, 8'h01, 8'h02};
        foreach (q[j]) send_byte(q[j]);
        repeat (3) @(negedge clk);
        check("midreset.pre_nwr", obs_w.size(), 2);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        obs_w.delete();
        q = '{8'h03, 8'h04, 8'h05, 8'h0F};
        foreach (q[j]) send_byte(q[j]);
        repeat (20) @(negedge clk);
        check("midreset.post_nwr", obs_w.size(), 0);
        check("midreset.post_busy", 32'(busy), 0);
        check("midreset.post_done", 32'(done), 0);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;

        obs_w.delete();
        exp_w.delete();
        q = '{8'hA5, 8'h00, 8'h04, 8'h01};
        model(q);
        foreach (q[j]) send_byte(q[j]);
        repeat (400) @(negedge clk);
        check("timeout.early_busy", 32'(busy), 1);
        check("timeout.early_err", 32'(err), 0);
        repeat (200) @(negedge clk);
`ifdef PROG_LOADER_TIMEOUT_EN
        exp_busy = 1'b0;
        exp_err  = 1'b1;
`endif
        check_result("timeout");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
        repeat (5) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            q = {};
            if ($urandom_range(0, 1) == 1) begin
                cs = 8'($urandom_range(0, 255));
                q.push_back(cs == 8'hA5 ? 8'h00 : cs);
            end
            n = $urandom_range(1, 6);
            q.push_back(8'hA5);
            q.push_back({4'($urandom_range(0, 15)), 4'h0});
            q.push_back(8'(n));
            cs = 8'h00;
            for (int k = 0; k < n; k++) begin
                q.push_back(8'($urandom_range(0, 255)));
                cs += q[q.size()-1];
            end
            q.push_back(($urandom_range(0, 3) == 0) ? cs ^ 8'h01 : cs);
            run(q, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time writer for program memory: receives a framed image over UART (8N1) and writes it byte-by-byte into the 2048x8 program store that the CPU fetches from.
- Sits between the board RX pin and the program memory write port.
- Holds the CPU (busy) while a load is in progress, then reports done or err.

Parameters:
CLK_HZ, 27000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_HZ/BAUD (integer division), must be at least 4
DEPTH, 2048, program memory depth in bytes; length fields above DEPTH are rejected
TIMEOUT_CYC, 2700000, idle-gap limit in clk cycles; used only with PROG_LOADER_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
rx  in  1  UART serial input, idle high, asynchronous to clk
mem_we  out  1  one-cycle write strobe to program memory
mem_addr  out  12  write address
mem_wdata  out  8  write data
busy  out  1  load in progress; CPU must be held in reset while high
done  out  1  last load succeeded (sticky)
err  out  1  last load failed (sticky)

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0. FSM goes to IDLE and the RX engine goes to idle. Reset mid-load aborts the load with no further writes.
- RX engine:
  - rx passes through a 2-FF synchronizer.
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at DIV/2; if it is high, the frame is discarded.
  - Data bits are sampled every DIV cycles after that point, LSB first.
  - The stop bit is sampled at the next DIV interval.
  - A stop bit of 0 is a framing error: the byte is dropped and, if FSM is not in IDLE, the FSM goes to ERR.
  - A valid byte raises an internal 1-cycle byte_valid.
- Frame protocol: 0xA5, LEN_H, LEN_L, LEN data bytes, CSUM. LEN = {LEN_H[3:0], LEN_L}; LEN_H[7:4] are ignored. CSUM = 8-bit sum mod 256 of the data bytes.
- FSM states:
  - IDLE: non-0xA5 bytes are ignored. On 0xA5: busy<=1, done<=0, err<=0, next state LEN_H.
  - LEN_H -> LEN_L on a byte.
  - LEN_L: on a byte, compute LEN. If LEN>DEPTH -> ERR. If LEN==0 -> CSUM with sum=0. Otherwise -> DATA with count=LEN, addr=0, sum=0.
  - DATA: on each byte, drive mem_we=1 for exactly one cycle with mem_addr=addr and mem_wdata=byte. Then addr+=1, sum+=byte, count-=1. When count reaches 0 -> CSUM.
  - CSUM: on a byte, next state OK if byte==sum, else ERR.
  - OK: done<=1, busy<=0, next state IDLE (single cycle).
  - ERR: err<=1, busy<=0, next state IDLE (single cycle).
- Latency: mem_we is asserted in the cycle after byte_valid.
- busy rises in the cycle after the header byte_valid.
- Memory already written before an error is not rolled back; err alone marks the image invalid.
- A 0xA5 received while not in IDLE is treated as ordinary data or length, never as a restart.
- mem_addr holds its last value when mem_we=0. Address arithmetic is 12-bit; with LEN<=DEPTH it never wraps.

Optional Feature:
PROG_LOADER_TIMEOUT_EN
- Defined: a gap counter reloads on every byte_valid and counts only while FSM is in LEN_H/LEN_L/DATA/CSUM. When it reaches TIMEOUT_CYC with no byte, FSM -> ERR (err=1, busy=0).
- Undefined: no counter; the loader waits indefinitely for the next byte.

Test Plan (CLK_HZ=1000000, BAUD=100000, DIV=10, TIMEOUT_CYC=500):
- Send A5 00 03 11 22 33 66 -> writes (0,11),(1,22),(2,33), three mem_we pulses of 1 cycle each; done=1, err=0, busy=0 after the CSUM byte.
- Send A5 00 02 10 20 31 (bad sum, expected 30) -> two writes, then err=1, done=0, busy=0.
- Send 00 FF A5 00 00 00 -> leading bytes ignored, no writes, done=1.
- Send A5 08 01 -> LEN=2049 > DEPTH -> err=1, no writes.
- During DATA, a frame with stop bit 0 -> err=1. Separately, assert reset mid-DATA -> all outputs return to 0 and no further mem_we.
- With PROG_LOADER_TIMEOUT_EN: A5 00 04 01 then rx idle for 600 cycles -> err=1 about 500 cycles after byte 01. Without the macro, busy stays 1.
